// File: rtl/vsram_bank_writer.sv
// Buffered write issuer for a banked vSRAM: requests are queued in a small FIFO
// and drained one per cycle onto a one-hot set of registered bank write ports.
module vsram_bank_writer #(
    parameter int NUM_BANKS  = 4,
    parameter int DATA_W     = 48,
    parameter int COL_W      = 10,
    parameter int ADDR_W     = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [COL_W-1:0]              in_colNum_info,
    input  logic                          in_section,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_last,
    output logic [NUM_BANKS*ADDR_W-1:0]   bank_addr,
    output logic [NUM_BANKS-1:0]          bank_we,
    output logic [NUM_BANKS*DATA_W-1:0]   bank_data,
    output logic                          write_done,
    output logic                          batch_done,
    output logic [15:0]                   write_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BANK_W  = $clog2(NUM_BANKS);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = BANK_W + ADDR_W + DATA_W + 1;

    generate
        if (NUM_BANKS < 2 || NUM_BANKS > 16 || (1 << BANK_W) != NUM_BANKS) begin : gBadBanks
            $error("NUM_BANKS must be a power of two in 2..16");
        end
        if (FIFO_DEPTH < 2 || (1 << PTR_W) != FIFO_DEPTH) begin : gBadDepth
            $error("FIFO_DEPTH must be a power of two >= 2");
        end
        if (ADDR_W != 1 + COL_W - BANK_W) begin : gBadAddr
            $error("ADDR_W must equal 1 + COL_W - log2(NUM_BANKS)");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ISSUE, PAUSE} state_t;

    state_t stateReg, stateNext;

    logic [ENTRY_W-1:0] fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtrReg, rdPtrReg;
    logic [PTR_W:0]     levelReg;

    logic               push, pop;
    logic [ENTRY_W-1:0] popEntry;
    logic [BANK_W-1:0]  popBank;
    logic [ADDR_W-1:0]  popAddr;
    logic [DATA_W-1:0]  popData;
    logic               popLast;

    logic [NUM_BANKS-1:0]        bankHit;
    logic [NUM_BANKS*ADDR_W-1:0] bankAddrNext;
    logic [NUM_BANKS*DATA_W-1:0] bankDataNext;

    logic [NUM_BANKS-1:0]        bankWeReg;
    logic [NUM_BANKS*ADDR_W-1:0] bankAddrReg;
    logic [NUM_BANKS*DATA_W-1:0] bankDataReg;
    logic                        writeDoneReg, batchDoneReg;
    logic [15:0]                 writeCountReg;

    // Holding in_ready low during reset keeps anything from landing in a FIFO being cleared.
    assign in_ready = reset & enable & (levelReg < (PTR_W+1)'(FIFO_DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = (stateReg == ISSUE) & enable & (levelReg != '0);

    // Storage carries no reset; validity is tracked solely by the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem[wrPtrReg] <= {in_colNum_info[BANK_W-1:0], in_section,
                                  in_colNum_info[COL_W-1:BANK_W], in_data, in_last};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            levelReg <= '0;
        end else begin
            if (push) wrPtrReg <= wrPtrReg + PTR_W'(1);
            if (pop)  rdPtrReg <= rdPtrReg + PTR_W'(1);
            levelReg <= levelReg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    assign popEntry = fifoMem[rdPtrReg];
    assign popBank  = popEntry[ENTRY_W-1 -: BANK_W];
    assign popAddr  = popEntry[DATA_W+1 +: ADDR_W];
    assign popData  = popEntry[1 +: DATA_W];
    assign popLast  = popEntry[0];

    always_ff @(posedge clock) begin
        if (!reset) stateReg <= IDLE;
        else        stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (!enable)               stateNext = PAUSE;
                else if (levelReg != '0)   stateNext = ISSUE;
            end
            ISSUE: begin
                // Stay while this pop leaves something behind or a new entry arrives.
                if (!enable)                                        stateNext = PAUSE;
                else if (levelReg <= (PTR_W+1)'(1) && !push)        stateNext = IDLE;
            end
            PAUSE: begin
                if (enable) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : gBank
            assign bankHit[gi]                        = pop && (popBank == BANK_W'(gi));
            assign bankAddrNext[gi*ADDR_W +: ADDR_W]  = bankHit[gi] ? popAddr : {ADDR_W{1'b1}};
            assign bankDataNext[gi*DATA_W +: DATA_W]  = bankHit[gi] ? popData : '0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            bankWeReg     <= '0;
            bankAddrReg   <= '1;
            bankDataReg   <= '0;
            writeDoneReg  <= 1'b0;
            batchDoneReg  <= 1'b0;
            writeCountReg <= '0;
        end else begin
            bankWeReg     <= bankHit;
            bankAddrReg   <= bankAddrNext;
            bankDataReg   <= bankDataNext;
            writeDoneReg  <= pop;
            batchDoneReg  <= pop & popLast;
            if (pop) writeCountReg <= writeCountReg + 16'd1;
        end
    end

    assign bank_we     = bankWeReg;
    assign bank_addr   = bankAddrReg;
    assign bank_data   = bankDataReg;
    assign write_done  = writeDoneReg;
    assign batch_done  = batchDoneReg;
    assign write_count = writeCountReg;
    assign fifo_level  = levelReg;

endmodule

// File: tb/tb_vsram_bank_writer.sv
// Directed bench for vsram_bank_writer: scoreboard of accepted requests checked
// against every bank write, plus targeted latency/full/pause/reset checks.
module tb_vsram_bank_writer;

    typedef struct {
        logic [1:0]  bank;
        logic [8:0]  addr;
        logic [47:0] data;
        logic        last;
    } ent_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset, enable, inValid, inSection, inLast;
    logic [9:0]   inCol;
    logic [47:0]  inData;
    logic         inReady, writeDone, batchDone;
    logic [35:0]  bankAddr;
    logic [3:0]   bankWe;
    logic [191:0] bankData;
    logic [15:0]  writeCount;
    logic [2:0]   fifoLevel;

    logic         en8, valid8, section8, last8, ready8, done8, batch8;
    logic [10:0]  col8;
    logic [47:0]  data8;
    logic [71:0]  addr8;
    logic [7:0]   we8;
    logic [383:0] bankData8;
    logic [15:0]  count8;
    logic [2:0]   level8;

    vsram_bank_writer dut (
        .clock(clock), .reset(reset), .enable(enable), .in_valid(inValid), .in_ready(inReady),
        .in_colNum_info(inCol), .in_section(inSection), .in_data(inData), .in_last(inLast),
        .bank_addr(bankAddr), .bank_we(bankWe), .bank_data(bankData), .write_done(writeDone),
        .batch_done(batchDone), .write_count(writeCount), .fifo_level(fifoLevel)
    );

    vsram_bank_writer #(.NUM_BANKS(8), .COL_W(11), .ADDR_W(9)) dut8 (
        .clock(clock), .reset(reset), .enable(en8), .in_valid(valid8), .in_ready(ready8),
        .in_colNum_info(col8), .in_section(section8), .in_data(data8), .in_last(last8),
        .bank_addr(addr8), .bank_we(we8), .bank_data(bankData8), .write_done(done8),
        .batch_done(batch8), .write_count(count8), .fifo_level(level8)
    );

    int   nVec = 0;
    int   nMis = 0;
    int   expWc = 0;
    int   wrSeen = 0;
    int   base;
    logic lastAcc, lastReady;
    logic [8:0] hist;
    ent_t sbq[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        ent_t         e;
        logic [35:0]  ea;
        logic [191:0] ed;
        if (writeDone === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_write", 256'(writeDone), 256'd0);
            end else begin
                e  = sbq.pop_front();
                ea = '1;
                ed = '0;
                ea[e.bank*9 +: 9]   = e.addr;
                ed[e.bank*48 +: 48] = e.data;
                expWc = (expWc + 1) & 16'hFFFF;
                wrSeen++;
                chk("bank_we", 256'(bankWe), 256'(4'b0001 << e.bank));
                chk("bank_addr", 256'(bankAddr), 256'(ea));
                chk("bank_data", 256'(bankData), 256'(ed));
                chk("batch_done", 256'(batchDone), 256'(e.last));
            end
        end else begin
            chk("idle_we", 256'(bankWe), 256'd0);
            chk("idle_addr", 256'(bankAddr), 256'({36{1'b1}}));
            chk("idle_data", 256'(bankData), 256'd0);
            chk("idle_batch", 256'(batchDone), 256'd0);
        end
        chk("write_count", 256'(writeCount), 256'(expWc));
    endtask

    // One clock: drive inputs, note acceptance, then check outputs after the edge.
    task automatic cyc(input logic v, input logic [9:0] col, input logic sec,
                       input logic [47:0] d, input logic lst, input logic en, input logic rst);
        ent_t e;
        inValid = v; inCol = col; inSection = sec; inData = d; inLast = lst;
        enable = en; reset = rst;
        #1;
        lastReady = inReady;
        lastAcc   = v && inReady;
        if (lastAcc) begin
            e.bank = col[1:0];
            e.addr = {sec, col[9:2]};
            e.data = d;
            e.last = lst;
            sbq.push_back(e);
        end
        @(posedge clock);
        #1;
        if (!rst) begin
            sbq.delete();
            expWc = 0;
        end
        monitor();
    endtask

    task automatic idle(input logic en);
        cyc(1'b0, 10'd0, 1'b0, 48'd0, 1'b0, en, 1'b1);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; inValid = 1'b0; inCol = '0; inSection = 1'b0;
        inData = '0; inLast = 1'b0;
        en8 = 1'b1; valid8 = 1'b0; col8 = '0; section8 = 1'b0; data8 = '0; last8 = 1'b0;
        @(posedge clock);
        #1;

        // Reset state
        cyc(1'b0, 10'd0, 1'b0, 48'd0, 1'b0, 1'b1, 1'b0);
        chk("rst_level", 256'(fifoLevel), 256'd0);
        chk("rst_ready", 256'(inReady), 256'd0);
        chk("rst_done", 256'(writeDone), 256'd0);
        idle(1'b1);
        chk("ready_after_reset", 256'(lastReady), 256'd1);

        // Single write and its two-edge latency
        cyc(1'b1, 10'h00E, 1'b1, 48'hABCD, 1'b1, 1'b1, 1'b1);
        chk("single_acc", 256'(lastAcc), 256'd1);
        chk("single_level", 256'(fifoLevel), 256'd1);
        idle(1'b1);
        chk("lat_k1_done", 256'(writeDone), 256'd0);
        idle(1'b1);
        chk("lat_k2_done", 256'(writeDone), 256'd1);
        chk("single_we", 256'(bankWe), 256'(4'b0100));
        chk("single_addr", 256'(bankAddr), 256'({9'h1FF, 9'h103, 9'h1FF, 9'h1FF}));
        chk("single_data", 256'(bankData), 256'({48'h0, 48'hABCD, 48'h0, 48'h0}));
        chk("single_batch", 256'(batchDone), 256'd1);
        chk("single_count", 256'(writeCount), 256'd1);
        idle(1'b1);
        chk("single_after_done", 256'(writeDone), 256'd0);
        chk("single_after_level", 256'(fifoLevel), 256'd0);

        // Back-to-back stream to banks 0,1,2,3,0,1
        hist = '0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, {8'(i + 16), 2'(i % 4)}, i[0], 48'h100 + 48'(i), (i == 5), 1'b1, 1'b1);
            chk("stream_ready", 256'(lastReady), 256'd1);
            hist[i] = writeDone;
        end
        for (int i = 6; i < 9; i++) begin
            idle(1'b1);
            hist[i] = writeDone;
        end
        chk("stream_done_pattern", 256'(hist), 256'(9'b011111100));

        // Full FIFO: alternate enable so entries arrive while nothing issues
        idle(1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, {8'(i + 40), 2'(3 - i)}, 1'b1, 48'h2000 + 48'(i), (i == 3), 1'b1, 1'b1);
            chk("full_push_acc", 256'(lastAcc), 256'd1);
            idle(1'b0);
        end
        chk("full_level", 256'(fifoLevel), 256'd4);
        cyc(1'b1, 10'h3FF, 1'b0, 48'hDEAD, 1'b0, 1'b1, 1'b1);
        chk("full_ready", 256'(lastReady), 256'd0);
        base = wrSeen;
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("full_drain_writes", 256'(wrSeen - base), 256'd4);
        chk("full_drain_level", 256'(fifoLevel), 256'd0);

        // Pause mid-stream after 2 of 5 writes
        cyc(1'b0, 10'd0, 1'b0, 48'd0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, {8'(i + 80), 2'(i)}, 1'b0, 48'h3000 + 48'(i), 1'b0, 1'b1, 1'b1);
            idle(1'b0);
        end
        base = wrSeen;
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        cyc(1'b1, {8'd99, 2'd2}, 1'b1, 48'h3004, 1'b1, 1'b1, 1'b1);
        chk("pause_fifth_acc", 256'(lastAcc), 256'd1);
        chk("pause_pre_writes", 256'(wrSeen - base), 256'd2);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk("pause_we", 256'(bankWe), 256'd0);
            chk("pause_done", 256'(writeDone), 256'd0);
        end
        for (int i = 0; i < 10; i++) idle(1'b1);
        chk("pause_total_writes", 256'(wrSeen - base), 256'd5);
        chk("pause_count", 256'(writeCount), 256'd5);

        // Reset with 3 entries queued
        idle(1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, {8'(i + 120), 2'(i)}, 1'b1, 48'h4000 + 48'(i), 1'b0, 1'b1, 1'b1);
            idle(1'b0);
        end
        idle(1'b1);
        cyc(1'b0, 10'd0, 1'b0, 48'd0, 1'b0, 1'b1, 1'b0);
        chk("midrst_level", 256'(fifoLevel), 256'd0);
        chk("midrst_count", 256'(writeCount), 256'd0);
        chk("midrst_done", 256'(writeDone), 256'd0);
        chk("midrst_ready", 256'(inReady), 256'd0);
        base = wrSeen;
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("midrst_no_writes", 256'(wrSeen - base), 256'd0);
        chk("midrst_count_held", 256'(writeCount), 256'd0);

        // Eight-bank instance: column 0x7FF in section 0
        valid8 = 1'b1; col8 = 11'h7FF; section8 = 1'b0; data8 = 48'h123456; last8 = 1'b1;
        #1;
        chk("p8_ready", 256'(ready8), 256'd1);
        idle(1'b1);
        valid8 = 1'b0;
        idle(1'b1);
        chk("p8_k1_done", 256'(done8), 256'd0);
        idle(1'b1);
        chk("p8_we", 256'(we8), 256'(8'h80));
        chk("p8_addr", 256'(addr8), 256'({9'h0FF, {7{9'h1FF}}}));
        chk("p8_data", 256'(bankData8[7*48 +: 48]), 256'(48'h123456));
        chk("p8_done", 256'(done8), 256'd1);

        chk("scoreboard_empty", 256'(sbq.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/vsram_bank_writer.md
VSRAM_BANK_WRITER -- requirements
Module: vsram_bank_writer

Interface
REQ-001 SHALL provide these parameters (name, default, meaning):
- NUM_BANKS, 4, number of vSRAM banks; power of two, 2..16.
- DATA_W, 48, write data width.
- COL_W, 10, width of the incoming column index.
- ADDR_W, 9, bank address width; SHALL equal 1 + COL_W - log2(NUM_BANKS), else elaboration error.
- FIFO_DEPTH, 4, input buffer entries; power of two, >= 2.

REQ-002 SHALL provide these ports (name, direction, width, meaning):
- clock, in, 1, sole clock; all state on the rising edge.
- reset, in, 1, synchronous active-low reset.
- enable, in, 1, 0 pauses the block (see REQ-013).
- in_valid, in, 1, write request present.
- in_ready, out, 1, block can accept a request.
- in_colNum_info, in, COL_W, bank select in the low bits, row in the high bits.
- in_section, in, 1, vSRAM half select; becomes the address MSB.
- in_data, in, DATA_W, write data.
- in_last, in, 1, marks the final write of a batch.
- bank_addr, out, NUM_BANKS*ADDR_W, per-bank write address; bank b in slice b.
- bank_we, out, NUM_BANKS, per-bank write enable.
- bank_data, out, NUM_BANKS*DATA_W, per-bank write data.
- write_done, out, 1, one-cycle pulse for each bank write issued.
- batch_done, out, 1, one-cycle pulse when an in_last entry is written.
- write_count, out, 16, bank writes issued since reset, wrapping.
- fifo_level, out, log2(FIFO_DEPTH)+1, occupied entries.

Function
REQ-003 SHALL accept a request on a rising edge where in_valid and in_ready are both 1.
- The accepted request SHALL be stored in the FIFO as {bank, addr, data, last}.
- bank = in_colNum_info[log2(NUM_BANKS)-1:0].
- addr = {in_section, in_colNum_info[COL_W-1:log2(NUM_BANKS)]}.

REQ-004 in_ready SHALL equal enable AND (fifo_level < FIFO_DEPTH).
- There is no full-FIFO bypass, so a push and a pop in the same cycle never race on a full FIFO.

REQ-005 The state machine SHALL have three states: IDLE, ISSUE and PAUSE.
- IDLE to ISSUE when the FIFO is non-empty and enable = 1.
- ISSUE to IDLE when the FIFO will be empty after the current pop and there is no push.
- ISSUE or IDLE to PAUSE when enable = 0.
- PAUSE to IDLE when enable = 1.

REQ-006 In ISSUE, the block SHALL pop exactly one entry per cycle.
- On the next edge it SHALL register bank_we[bank] = 1, bank_addr slice = addr and bank_data slice = data.
- All other banks SHALL be idle in that cycle.

REQ-007 Idle banks SHALL drive we = 0, an address of all ones and data of zero.

REQ-008 Latency: a request accepted at edge k into an empty FIFO while the block is in IDLE SHALL appear on the bank outputs after edge k+2.
- With back-to-back requests, throughput SHALL be one write per cycle.

REQ-009 bank outputs, write_done and batch_done SHALL be registered, and all SHALL change on the same edge.
- write_done = 1 in exactly the cycle the write appears on the bank outputs.
- batch_done = 1 in that same cycle only if the entry's last flag is set.

REQ-010 write_count SHALL increment by 1 on the same edge that write_done is set.
- It SHALL wrap from 0xFFFF to 0x0000.

REQ-011 fifo_level SHALL update every cycle as +1 on a push, -1 on a pop, and unchanged when a push and a pop occur together.
- The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.

REQ-012 Requests SHALL be written in acceptance order. Consecutive writes to the same bank and address are legal and each SHALL be issued.

REQ-013 When enable = 0:
- no pop and no push;
- the FIFO contents and write_count SHALL be held;
- on the next edge the bank outputs go idle per REQ-007, and write_done and batch_done go to 0.

REQ-014 When enable returns to 1, issue SHALL resume with the oldest held entry. No entry SHALL be lost or duplicated.

Reset
REQ-015 On a rising edge with reset = 0, regardless of state or enable, the block SHALL:
- clear the FIFO, so fifo_level = 0;
- go to state IDLE;
- set write_count to 0;
- set write_done and batch_done to 0;
- set all bank_we to 0, all bank_addr to all ones and all bank_data to 0.

REQ-016 While reset = 0, in_ready SHALL be 0.
- Any entries in flight when reset is asserted mid-operation SHALL be discarded and never issued.

Verification
REQ-017 Single write with default parameters:
- Stimulus: in_colNum_info = 10'h00E, in_section = 1, in_data = 48'hABCD, in_last = 1, accepted at edge k.
- Response after edge k+2: bank_we = 4'b0100 and bank 2 address = 9'h103, with data 48'hABCD, write_done = 1, batch_done = 1, write_count = 1.
- Other banks: address 9'h1FF, data 0.

REQ-018 Back-to-back stream:
- Stimulus: 6 requests on consecutive cycles to banks 0,1,2,3,0,1.
- Response: 6 consecutive cycles with write_done = 1 and the one-hot bank_we following that bank order; in_ready never drops.

REQ-019 Full FIFO:
- Stimulus: hold enable = 1 and push 4 entries while the issue side is stalled by a forced enable pause; then release.
- Response: fifo_level = 4 and in_ready = 0 at full. After release, 4 writes issue in acceptance order and fifo_level returns to 0.

REQ-020 Pause mid-stream:
- Stimulus: drop enable for 3 cycles after 2 of 5 queued writes have issued.
- Response: bank_we = 0 for those cycles, then the remaining 3 writes issue in order and write_count = 5.

REQ-021 Reset mid-operation:
- Stimulus: assert reset with 3 entries queued.
- Response: the next cycle shows fifo_level = 0, write_count = 0 and all outputs at their reset values; no further writes issue after reset is released.

REQ-022 Parameter sweep:
- Stimulus: NUM_BANKS = 8, COL_W = 11, ADDR_W = 9; in_colNum_info = 11'h7FF, in_section = 0.
- Response: bank 7 written at address 9'h0FF.
